// File: rtl/sm_hex_display_scan_pkg.sv
// Shared constants for the 3-digit seven-segment scan controller.
// Segment bit positions, slot geometry and per-slot state encoding.
package sm_hex_display_scan_pkg;

  localparam int NDIG          = 3;
  localparam int SLOT_SUBTICKS = 16;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [1:0] ST_BLANK = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_OFF   = 2'd2;

  function automatic logic [2:0] dig_sel_n(input logic [1:0] d);
    case (d)
      2'd0:    dig_sel_n = 3'b110;
      2'd1:    dig_sel_n = 3'b101;
      2'd2:    dig_sel_n = 3'b011;
      default: dig_sel_n = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/sm_hex_display_timebase.sv
// Prescaler, sub-tick and digit counters for the display scan.
// Held at zero while the display is disabled.
module sm_hex_display_timebase
  import sm_hex_display_scan_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       enable,
  output logic [3:0] sub,
  output logic [1:0] dig,
  output logic       slot_start,
  output logic       frame_end
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [3:0] SMAX = 4'(SLOT_SUBTICKS - 1);
  localparam logic [1:0] DMAX = 2'(NDIG - 1);

  logic [PW-1:0] pre;
  logic          stb;

  assign stb = (pre == PMAX);

  always_ff @(posedge clkin) begin
    if (rst || !enable) begin
      pre <= '0;
      sub <= '0;
      dig <= '0;
    end else begin
      pre <= stb ? '0 : pre + PW'(1);
      if (stb) begin
        sub <= (sub == SMAX) ? 4'd0 : sub + 4'd1;
        if (sub == SMAX)
          dig <= (dig == DMAX) ? 2'd0 : dig + 2'd1;
      end
    end
  end

  assign slot_start = enable && (pre == '0) && (sub == 4'd0);
  assign frame_end  = enable && stb && (sub == SMAX) && (dig == DMAX);

endmodule

// File: rtl/sm_hex_display_scan.sv
// Multiplexed 3-digit seven-segment scanner with dead-time,
// PWM brightness and frame-atomic double-buffered patterns.
module sm_hex_display_scan
  import sm_hex_display_scan_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] brightness,
  input  logic       enable,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [2:0] dig_n,
  output logic       frame_tick
);

  logic [3:0] sub;
  logic [1:0] dig;
  logic       slot_start;
  logic       frame_end;

  logic [7:0] shadow [NDIG];
  logic [7:0] active [NDIG];
  logic [3:0] bright_q;
  logic [1:0] st;

  sm_hex_display_timebase #(
    .PRESCALE(PRESCALE)
  ) u_tb (
    .clkin     (clkin),
    .rst       (rst),
    .enable    (enable),
    .sub       (sub),
    .dig       (dig),
    .slot_start(slot_start),
    .frame_end (frame_end)
  );

  // Commit copies the pre-write shadow, so a colliding write waits a frame.
  always_ff @(posedge clkin) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (frame_end) begin
        for (int i = 0; i < NDIG; i++)
          active[i] <= shadow[i];
      end
      if (wr_en && (wr_addr != 2'd3))
        shadow[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst)
      bright_q <= '0;
    else if (slot_start)
      bright_q <= brightness;
  end

  always_comb begin
    st = ST_BLANK;
    if (!enable || sub == 4'd0)
      st = ST_BLANK;
    else if (sub <= bright_q)
      st = ST_ON;
    else
      st = ST_OFF;
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      dig_n      <= 3'b111;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (st == ST_ON) begin
        dig_n <= dig_sel_n(dig);
        seg_n <= ~active[dig][SEG_G:SEG_A];
        dp_n  <= ~active[dig][SEG_DP];
      end else begin
        dig_n <= 3'b111;
        seg_n <= 7'h7F;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Self-checking bench for sm_hex_display_scan (PRESCALE=2):
// frame-position reference model plus directed literal checks.
module tb_sm_hex_display_scan;

  localparam int P  = 2;
  localparam int FL = 48 * P;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] brightness = 4'd15;
  logic       enable = 1'b1;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [2:0] dig_n;
  logic       frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  sm_hex_display_scan #(.PRESCALE(P)) dut (
    .clkin     (clkin),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .brightness(brightness),
    .enable    (enable),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .dig_n     (dig_n),
    .frame_tick(frame_tick)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame counted since (re)start.
  int         k = 0;
  int         m_bq = 0;
  logic [7:0] m_sh [3];
  logic [7:0] m_act [3];
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;
  logic [2:0] e_dig = 3'b111;
  logic       e_ft = 1'b0;

  always @(posedge clkin) begin
    int pos, d, s, p;
    bit lit;
    logic [2:0] one;
    if (rst) begin
      k = 0;
      m_bq = 0;
      for (int i = 0; i < 3; i++) begin
        m_sh[i] = '0;
        m_act[i] = '0;
      end
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 3'b111; e_ft = 1'b0;
    end else begin
      if (!enable) begin
        k = 0;
        e_seg = 7'h7F; e_dp = 1'b1; e_dig = 3'b111; e_ft = 1'b0;
      end else begin
        pos = k % FL;
        d = pos / (16 * P);
        s = (pos / P) % 16;
        p = pos % P;
        lit = (s >= 1) && (s <= m_bq);
        one = 3'b001 << d;
        e_dig = lit ? ~one : 3'b111;
        e_seg = lit ? ~m_act[d][6:0] : 7'h7F;
        e_dp  = lit ? ~m_act[d][7] : 1'b1;
        e_ft  = (pos == FL - 1);
        if (e_ft)
          for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
        if (p == 0 && s == 0) m_bq = int'(brightness);
        k++;
      end
      if (wr_en && wr_addr != 2'd3) m_sh[wr_addr] = wr_data;
    end
  end

  initial begin
    @(posedge clkin);
    forever begin
      @(negedge clkin);
      check("model", {20'h0, seg_n, dp_n, dig_n, frame_tick},
            {20'h0, e_seg, e_dp, e_dig, e_ft});
    end
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic wait_ft(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame_tick && n < 4 * FL);
    if (!frame_tick) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_dig(input string name, input logic [2:0] v);
    int n = 0;
    while (dig_n !== v && n < 4 * FL) begin
      tick();
      n++;
    end
    if (dig_n !== v) check({name, "_timeout"}, {29'h0, dig_n}, {29'h0, v});
  endtask

  task automatic bright_frame(input logic [3:0] b, input int expn);
    int cnt = 0;
    brightness = b;
    wait_ft("bright_sync");
    repeat (FL) begin
      tick();
      if (dig_n != 3'b111) cnt++;
    end
    check($sformatf("lit_cycles_b%0d", b), cnt, expn);
  endtask

  initial begin
    int n;
    bit saw, dark;
    int lit_n;
    repeat (3) tick();
    check("reset_out", {20'h0, seg_n, dp_n, dig_n, frame_tick},
          {20'h0, 7'h7F, 1'b1, 3'b111, 1'b0});
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_tick && n < 300);
    check("first_ft_latency", n, 96);

    // write digit 1 mid-frame; visible only after the next commit
    repeat (10) tick();
    wr_addr = 2'd1; wr_data = 8'h06; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_dig("d1_pre", 3'b101);
    check("d1_before_commit", {25'h0, seg_n}, {25'h0, 7'h7F});
    wait_ft("d1_commit");
    wait_dig("d1_post", 3'b101);
    check("d1_after_commit", {25'h0, seg_n}, {25'h0, 7'h79});

    bright_frame(4'd0, 0);
    bright_frame(4'd15, 90);
    bright_frame(4'd7, 42);
    brightness = 4'd15;

    // write exactly on the commit edge
    wait_ft("col_sync");
    repeat (FL - 1) tick();
    wr_addr = 2'd0; wr_data = 8'hFF; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check("collide_ft", {31'h0, frame_tick}, 1);
    wait_dig("col_old", 3'b110);
    check("collide_old", {24'h0, seg_n, dp_n}, {24'h0, 7'h7F, 1'b1});
    wait_ft("col_next");
    wait_dig("col_new", 3'b110);
    check("collide_new", {24'h0, seg_n, dp_n}, {24'h0, 7'h00, 1'b0});

    // enable drop while digit 1 is lit
    wait_dig("en_d1", 3'b101);
    enable = 1'b0;
    tick();
    check("en_blank", {21'h0, seg_n, dp_n, dig_n},
          {21'h0, 7'h7F, 1'b1, 3'b111});
    saw = 0;
    repeat (200) begin
      tick();
      if (frame_tick) saw = 1;
    end
    check("en_no_ft", {31'h0, saw}, 0);
    enable = 1'b1;
    n = 0;
    while (dig_n == 3'b111 && n < 100) begin
      tick();
      n++;
    end
    check("en_first_dig", {29'h0, dig_n}, {29'h0, 3'b110});

    // reset mid-frame with digit 0 lit
    wait_dig("rst_d0", 3'b110);
    rst = 1'b1;
    tick();
    check("rst_mid", {20'h0, seg_n, dp_n, dig_n, frame_tick},
          {20'h0, 7'h7F, 1'b1, 3'b111, 1'b0});
    rst = 1'b0;
    dark = 1;
    lit_n = 0;
    repeat (2 * FL) begin
      tick();
      if (dig_n != 3'b111) lit_n++;
      if (seg_n != 7'h7F || dp_n != 1'b1) dark = 0;
    end
    check("rst_dark", {31'h0, dark}, 1);
    check("rst_scan_runs", {31'h0, lit_n > 0}, 1);

    // randomized traffic against the model
    repeat (4000) begin
      @(posedge clkin);
      #1;
      wr_en = ($urandom_range(0, 7) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      if ($urandom_range(0, 150) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 400) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 30) == 0) enable = 1'b1;
      rst = ($urandom_range(0, 1500) == 0);
    end
    rst = 1'b0;
    wr_en = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
